// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore-style datapath controls, mem_ready wait
// handshake, retired-instruction counter and sticky illegal-opcode trap.
// Optional feature: define MC_CTRL_JUMP_EN to decode opcode 000010 as a jump.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [3:0]       state
);

  localparam logic [3:0] ST_BOOT     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEMADR   = 4'd3;
  localparam logic [3:0] ST_MEMREAD  = 4'd4;
  localparam logic [3:0] ST_MEMWB    = 4'd5;
  localparam logic [3:0] ST_MEMWRITE = 4'd6;
  localparam logic [3:0] ST_EXECUTE  = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [3:0] ST_JUMP     = 4'd10;
  localparam logic [5:0] OP_J        = 6'b000010;
`endif
  localparam logic [3:0] ST_TRAP     = 4'd15;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register; reset drops straight to BOOT so every control output clears at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_BOOT;
    case (state_q)
      ST_BOOT:     state_d = ST_FETCH;
      ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = ST_JUMP;
`endif
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  state_d = mem_ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWRITE: state_d = mem_ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECUTE:  state_d = ST_ALUWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP:     state_d = ST_FETCH;
`endif
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_BOOT;
    endcase
  end

  // Control decode: a function of state, plus mem_ready for the handshake strobes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    trap          = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
      end
      ST_DECODE:   alu_src_b = 2'b11;
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ST_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`endif
      ST_TRAP:     trap = 1'b1;
      default:     ;
    endcase
  end

  // Retired counter wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle directed vectors push expected
// state/controls/retired; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;
  logic [3:0]  state;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .retired(retired),
    .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OR = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, BAD = 6'b111111;

  localparam logic [3:0] BOOT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3;
  localparam logic [3:0] MEMREAD = 4'd4, MEMWB = 4'd5, MEMWRITE = 4'd6, EXECUTE = 4'd7;
  localparam logic [3:0] ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, TRAP = 4'd15;

  // Control word: pw pwc iod mr mw irw m2r rd rw asa _ asb _ aop _ psrc _ done trap
  localparam logic [17:0] C_ZERO    = 18'b0000000000_00_00_00_00;
  localparam logic [17:0] C_FETCH_R = 18'b1001010000_01_00_00_00;
  localparam logic [17:0] C_FETCH_W = 18'b0001000000_01_00_00_00;
  localparam logic [17:0] C_DECODE  = 18'b0000000000_11_00_00_00;
  localparam logic [17:0] C_MEMADR  = 18'b0000000001_10_00_00_00;
  localparam logic [17:0] C_MEMRD   = 18'b0011000000_00_00_00_00;
  localparam logic [17:0] C_MEMWB   = 18'b0000001010_00_00_00_10;
  localparam logic [17:0] C_MEMWR_R = 18'b0010100000_00_00_00_10;
  localparam logic [17:0] C_MEMWR_W = 18'b0010100000_00_00_00_00;
  localparam logic [17:0] C_EXEC    = 18'b0000000001_00_10_00_00;
  localparam logic [17:0] C_ALUWB   = 18'b0000000110_00_00_00_10;
  localparam logic [17:0] C_BRANCH  = 18'b0100000001_00_01_01_10;
  localparam logic [17:0] C_JUMP    = 18'b1000000000_00_00_10_10;
  localparam logic [17:0] C_TRAP    = 18'b0000000000_00_00_00_01;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic        rst;
    logic [3:0]  st;
    logic [17:0] cw;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx = 0;

  logic [17:0] act_cw;
  assign act_cw = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_done, trap};

  task automatic add(input logic [5:0] op, input logic mr, input logic rst,
                     input logic [3:0] st, input logic [17:0] cw, input int ret);
    vec_t v;
    v.op = op; v.mr = mr; v.rst = rst; v.st = st; v.cw = cw; v.ret = 32'(ret);
    vecs.push_back(v);
  endtask

  // Monitor: compare whatever the DUT shows mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (state !== e.st || act_cw !== e.cw || retired !== e.ret) begin
        errors = errors + 1;
        $display("FAIL vec%0d: got state=%0d ctrl=%b retired=%0d, expected state=%0d ctrl=%b retired=%0d",
                 vidx, state, act_cw, retired, e.st, e.cw, e.ret);
      end
      vidx = vidx + 1;
    end
  end

  initial begin
    // Reset, then R-type
    add(OR, 1, 0, BOOT,     C_ZERO,    0);
    add(OR, 1, 1, BOOT,     C_ZERO,    0);
    add(OR, 1, 1, FETCH,    C_FETCH_R, 0);
    add(OR, 1, 1, DECODE,   C_DECODE,  0);
    add(OR, 1, 1, EXECUTE,  C_EXEC,    0);
    add(OR, 1, 1, ALUWB,    C_ALUWB,   0);
    // lw, sw, beq with zero-wait memory
    add(LW, 1, 1, FETCH,    C_FETCH_R, 1);
    add(LW, 1, 1, DECODE,   C_DECODE,  1);
    add(LW, 1, 1, MEMADR,   C_MEMADR,  1);
    add(LW, 1, 1, MEMREAD,  C_MEMRD,   1);
    add(LW, 1, 1, MEMWB,    C_MEMWB,   1);
    add(SW, 1, 1, FETCH,    C_FETCH_R, 2);
    add(SW, 1, 1, DECODE,   C_DECODE,  2);
    add(SW, 1, 1, MEMADR,   C_MEMADR,  2);
    add(SW, 1, 1, MEMWRITE, C_MEMWR_R, 2);
    add(BQ, 1, 1, FETCH,    C_FETCH_R, 3);
    add(BQ, 1, 1, DECODE,   C_DECODE,  3);
    add(BQ, 1, 1, BRANCH,   C_BRANCH,  3);
    // lw with 2 fetch waits and 3 read waits: 10 cycles
    add(LW, 0, 1, FETCH,    C_FETCH_W, 4);
    add(LW, 0, 1, FETCH,    C_FETCH_W, 4);
    add(LW, 1, 1, FETCH,    C_FETCH_R, 4);
    add(LW, 1, 1, DECODE,   C_DECODE,  4);
    add(LW, 1, 1, MEMADR,   C_MEMADR,  4);
    add(LW, 0, 1, MEMREAD,  C_MEMRD,   4);
    add(LW, 0, 1, MEMREAD,  C_MEMRD,   4);
    add(LW, 0, 1, MEMREAD,  C_MEMRD,   4);
    add(LW, 1, 1, MEMREAD,  C_MEMRD,   4);
    add(LW, 1, 1, MEMWB,    C_MEMWB,   4);
    // sw stalled in MEMWRITE, then reset asserted between edges
    add(SW, 1, 1, FETCH,    C_FETCH_R, 5);
    add(SW, 1, 1, DECODE,   C_DECODE,  5);
    add(SW, 1, 1, MEMADR,   C_MEMADR,  5);
    add(SW, 0, 1, MEMWRITE, C_MEMWR_W, 5);
    add(SW, 0, 0, BOOT,     C_ZERO,    0);
    add(JP, 1, 1, BOOT,     C_ZERO,    0);
    add(JP, 1, 1, FETCH,    C_FETCH_R, 0);
    add(JP, 1, 1, DECODE,   C_DECODE,  0);
`ifdef MC_CTRL_JUMP_EN
    add(JP,  1, 1, JUMP,    C_JUMP,    0);
    add(BAD, 1, 1, FETCH,   C_FETCH_R, 1);
    add(BAD, 1, 1, DECODE,  C_DECODE,  1);
    add(BAD, 1, 1, TRAP,    C_TRAP,    1);
    add(BAD, 0, 1, TRAP,    C_TRAP,    1);
    add(BAD, 1, 1, TRAP,    C_TRAP,    1);
    add(BAD, 1, 0, BOOT,    C_ZERO,    0);
`else
    add(JP,  1, 1, TRAP,    C_TRAP,    0);
    add(JP,  1, 1, TRAP,    C_TRAP,    0);
    add(BAD, 1, 0, BOOT,    C_ZERO,    0);
    add(BAD, 1, 1, BOOT,    C_ZERO,    0);
    add(BAD, 1, 1, FETCH,   C_FETCH_R, 0);
    add(BAD, 1, 1, DECODE,  C_DECODE,  0);
    add(BAD, 1, 1, TRAP,    C_TRAP,    0);
    add(BAD, 0, 1, TRAP,    C_TRAP,    0);
    add(BAD, 1, 0, BOOT,    C_ZERO,    0);
`endif
    add(OR, 1, 1, BOOT,     C_ZERO,    0);
    add(OR, 1, 1, FETCH,    C_FETCH_R, 0);

    // Drive each vector just after the rising edge; the monitor checks at the falling edge.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].mr;
      reset     = vecs[i].rst;
      exp_q.push_back(vecs[i]);
    end
    repeat (3) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
